modreduce_serial: RTL and testbench

Bit-serial modular reducer that consumes the 128-bit product from the pipelined Karatsuba multiplier and returns `P mod M` for a 64-bit modulus. It sits downstream of the multiplier in the modular-multiplier datapath. It accepts one product/modulus pair through a valid/ready handshake and runs a restoring shift-subtract remainder loop, one product bit per cycle. It holds the result until the consumer accepts it.

---
 rtl/modmult_pkg.sv | 14 +
 rtl/modred_cmpsub.sv | 16 +
 rtl/modreduce_serial.sv | 103 ++++++++++
 tb/tb_modreduce_serial.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/modmult_pkg.sv
// Shared constants and state encoding for the modular-multiplier datapath.
// Used by the serial reducer and the multiplier wrapper.
package modmult_pkg;

  localparam int W  = 64;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } modred_state_t;

endpackage

// File: rtl/modred_cmpsub.sv
// One restoring remainder step: subtract the modulus when the candidate reaches it.
// Purely combinational; the caller guarantees t < 2*M, so the result fits in W bits.
module modred_cmpsub #(
  parameter int W = 64
) (
  input  logic [W:0]   t_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] r_o
);

  logic [W:0] diff;

  assign diff = t_i - {1'b0, m_i};
  assign r_o  = (t_i >= {1'b0, m_i}) ? diff[W-1:0] : t_i[W-1:0];

endmodule

// File: rtl/modreduce_serial.sv
// Bit-serial P mod M: one product bit per cycle, 2W cycles per job, result held until taken.
// M == 0 skips the loop and reports err with R = 0.
module modreduce_serial
  import modmult_pkg::*;
#(
  parameter int W = modmult_pkg::W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] P,
  input  logic [W-1:0]   M,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   R,
  output logic           err,
  output logic           busy
);

  localparam int P_W = 2 * W;
  localparam int CW  = $clog2(P_W);

  modred_state_t  state_q, state_d;
  logic [P_W-1:0] p_q, p_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [W:0]     t;
  logic [W-1:0]   r_step;

  // Remainder stays below M, so the shifted candidate needs only one extra bit.
  assign t = {r_q, p_q[P_W-1]};

  modred_cmpsub #(.W(W)) u_cmpsub (
    .t_i (t),
    .m_i (m_q),
    .r_o (r_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          p_d     = P;
          m_d     = M;
          r_d     = '0;
          cnt_d   = CW'(P_W - 1);
          err_d   = (M == '0);
          state_d = (M == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        r_d   = r_step;
        p_d   = {p_q[P_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode only registered state.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign R         = r_q;
  assign err       = err_q;

endmodule

// File: tb/tb_modreduce_serial.sv
// Directed bench for modreduce_serial: hand-computed remainders, latency, back-pressure and reset abort.
module tb_modreduce_serial;

  localparam int W = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] p = '0;
  logic [W-1:0]   m = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   r;
  logic           err;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int seen;

  always #5 clock = ~clock;

  modreduce_serial #(.W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (p),
    .M         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (r),
    .err       (err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one job and returns just after its accept edge.
  task automatic send(input logic [2*W-1:0] pv, input logic [W-1:0] mv);
    int n;
    p = pv;
    m = mv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_R", r, 0);
    chk("rst_err", err, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // 1234*5678 mod 1000, with exact latency
    send(128'd7006652, 64'd1000);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_busy", in_ready, 0);
    wait_done(lat);
    chk("lat_normal", lat, 128);
    chk("R_7006652", r, 64'd652);
    chk("err_7006652", err, 0);
    pop();
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);

    // (2^64-1)^2 mod (2^64-1)
    send(128'hFFFFFFFFFFFFFFFE0000000000000001, 64'hFFFFFFFFFFFFFFFF);
    wait_done(lat);
    chk("done_sq", out_valid, 1);
    chk("R_sq", r, 64'd0);
    pop();

    // P < M passes through unchanged
    send(128'd121932631112635269, 64'h1FFFFFFFFFFFFFFF);
    wait_done(lat);
    chk("R_p_lt_m", r, 64'd121932631112635269);
    pop();

    // 2^127 + 5 mod (2^64-1) = 2^63 + 5, exercises the top product bit
    send(128'h80000000000000000000000000000005, 64'hFFFFFFFFFFFFFFFF);
    wait_done(lat);
    chk("R_top_bit", r, 64'h8000000000000005);
    pop();

    // M == 1 takes the full loop
    send(128'd12345, 64'd1);
    wait_done(lat);
    chk("lat_m1", lat, 128);
    chk("R_m1", r, 64'd0);
    chk("err_m1", err, 0);
    pop();

    // P == 0
    send(128'd0, 64'd13);
    wait_done(lat);
    chk("R_p0", r, 64'd0);
    pop();

    // M == 0: result is valid in the cycle right after accept
    send(128'd12345, 64'd0);
    chk("m0_out_valid", out_valid, 1);
    chk("m0_err", err, 1);
    chk("m0_R", r, 64'd0);
    chk("m0_busy", busy, 0);
    pop();

    // out_ready already high: DONE lasts exactly one cycle
    out_ready = 1'b1;
    send(128'd99, 64'd0);
    chk("early_rdy_valid", out_valid, 1);
    tick();
    chk("early_rdy_drop", out_valid, 0);
    chk("early_rdy_idle", in_ready, 1);
    out_ready = 1'b0;

    // Back-pressure: result held, new job refused until drained
    send(128'd1000, 64'd9);
    wait_done(lat);
    chk("bp_R_first", r, 64'd1);
    p = 128'd55;
    m = 64'd7;
    in_valid = 1'b1;
    repeat (10) tick();
    chk("bp_out_valid_held", out_valid, 1);
    chk("bp_R_held", r, 64'd1);
    chk("bp_err_held", err, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_not_busy", busy, 0);
    pop();
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted", busy, 1);
    wait_done(lat);
    chk("bp_R_second", r, 64'd6);
    pop();

    // Reset in the middle of BUSY discards the job
    send(128'd7006652, 64'd1000);
    repeat (49) tick();
    chk("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_R", r, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (200) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_valid_after_rst", seen, 0);

    send(128'd100, 64'd7);
    wait_done(lat);
    chk("post_rst_done", out_valid, 1);
    chk("post_rst_R", r, 64'd2);
    pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
